// File: rtl/bsg_mem_1rw_sync_mask_write_byte_synth.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Each byte lane is its own array, so synthesis sees one plain RAM per lane.
module bsg_mem_1rw_sync_mask_write_byte_synth #(
  parameter int els_p               = -1,
  parameter int data_width_p        = -1,
  parameter bit latch_last_read_p   = 1'b1,
  parameter int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int write_mask_width_lp = data_width_p / 8
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  input  logic                           w_i,
  input  logic [addr_width_lp-1:0]       addr_i,
  input  logic [data_width_p-1:0]        data_i,
  input  logic [write_mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]        data_o
);

  if (data_width_p % 8 != 0) begin : g_bad_width
    $error("bsg_mem_1rw_sync_mask_write_byte_synth: data_width_p=%0d is not a multiple of 8",
           data_width_p);
  end
  if (els_p < 1) begin : g_bad_els
    $error("bsg_mem_1rw_sync_mask_write_byte_synth: els_p=%0d must be >= 1", els_p);
  end
  if (1) begin : g_banner
    $info("bsg_mem_1rw_sync_mask_write_byte_synth: els_p=%0d data_width_p=%0d latch_last_read_p=%0d",
          els_p, data_width_p, latch_last_read_p);
  end

  logic                    addr_ok;
  logic                    rd_en;
  logic                    wr_en;
  logic                    read_v_q;
  logic                    read_v_d;
  logic [data_width_p-1:0] rd_data;

  // Out-of-range addresses (non-power-of-2 depth) must never alias onto a real entry.
  assign addr_ok  = ({1'b0, addr_i} < (addr_width_lp + 1)'(els_p));
  assign rd_en    = v_i & ~w_i;
  assign wr_en    = v_i & w_i & addr_ok & reset_n_i;
  assign read_v_d = rd_en;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      read_v_q <= 1'b0;
    end else begin
      read_v_q <= read_v_d;
    end
  end

  for (genvar k = 0; k < write_mask_width_lp; k++) begin : g_lane
    logic [7:0] mem_r [els_p];
    logic [7:0] rd_byte_q;
    logic [7:0] rd_byte_d;

    assign rd_byte_d = addr_ok ? mem_r[addr_i] : 8'h00;

    always_ff @(posedge clk_i) begin
      if (wr_en && write_mask_i[k]) begin
        mem_r[addr_i] <= data_i[8*k +: 8];
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rd_byte_q <= 8'h00;
      end else if (rd_en) begin
        rd_byte_q <= rd_byte_d;
      end
    end

    assign rd_data[8*k +: 8] = rd_byte_q;
  end

  // Without latching, data outside the post-read cycle is don't-care; drive zero.
  assign data_o = (latch_last_read_p || read_v_q) ? rd_data : '0;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_synth.sv
// Directed bench for the byte-masked 1RW RAM; a reference model pushes the expected
// data_o for every cycle into a queue that is popped after each rising edge.
module tb_bsg_mem_1rw_sync_mask_write_byte_synth;

  localparam int ELS = 16;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int MW  = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i;
  logic          w_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i;
  logic [MW-1:0] write_mask_i;
  logic [DW-1:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl_mem [ELS];
  logic [DW-1:0] mdl_last;
  logic [DW-1:0] exp_q [$];

  bsg_mem_1rw_sync_mask_write_byte_synth #(
    .els_p(ELS),
    .data_width_p(DW),
    .latch_last_read_p(1'b1)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .v_i(v_i),
    .w_i(w_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .write_mask_i(write_mask_i),
    .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model computes what data_o must be after this edge.
  task automatic step(input string tag, input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic [DW-1:0] exp;
    @(negedge clk_i);
    v_i = v; w_i = w; addr_i = a; data_i = d; write_mask_i = m;
    if (reset_n_i) begin
      if (v && !w) mdl_last = mdl_mem[a];
      if (v && w)
        for (int k = 0; k < MW; k++)
          if (m[k]) mdl_mem[a][8*k +: 8] = d[8*k +: 8];
    end else begin
      mdl_last = '0;
    end
    exp_q.push_back(mdl_last);
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, data_o, 'x);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, data_o, exp);
    end
  endtask

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; write_mask_i = '0;
    mdl_last = '0;
    for (int i = 0; i < ELS; i++) mdl_mem[i] = 'x;
    #1;
    chk("reset_data_o", data_o, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    step("idle_after_reset", 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    step("wr3_full",   1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    step("rd3_full",   1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    chk("rd3_full_const", data_o, 32'hDEADBEEF);

    step("wr3_partial", 1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101);
    chk("no_write_through", data_o, 32'hDEADBEEF);
    step("rd3_partial", 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    chk("rd3_partial_const", data_o, 32'hDE22BE44);

    step("rd3_again", 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step("hold_idle", 1'b0, 1'b0, 4'd3, 32'hFFFFFFFF, 4'hF);
      chk("hold_idle_const", data_o, 32'hDE22BE44);
    end
    step("wr5_hold", 1'b1, 1'b1, 4'd5, 32'hCAFEF00D, 4'hF);
    chk("wr5_hold_const", data_o, 32'hDE22BE44);
    step("rd5", 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    chk("rd5_const", data_o, 32'hCAFEF00D);

    step("wr5_zero_mask", 1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
    step("rd5_after_zero_mask", 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    chk("zero_mask_const", data_o, 32'hCAFEF00D);

    step("rd3_before_reset", 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_reset_immediate", data_o, 32'h0);
    mdl_last = '0;
    step("wr5_during_reset", 1'b1, 1'b1, 4'd5, 32'h0, 4'hF);
    step("rd3_during_reset", 1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step("idle_after_release", 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    chk("zero_until_read", data_o, 32'h0);
    step("rd5_retained", 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    chk("rd5_retained_const", data_o, 32'hCAFEF00D);

    step("wr0", 1'b1, 1'b1, 4'd0,  32'h00000001, 4'hF);
    step("wr15", 1'b1, 1'b1, 4'd15, 32'h80000000, 4'hF);
    step("rd0", 1'b1, 1'b0, 4'd0,  32'h0, 4'h0);
    chk("rd0_const", data_o, 32'h00000001);
    step("rd15", 1'b1, 1'b0, 4'd15, 32'h0, 4'h0);
    chk("rd15_const", data_o, 32'h80000000);

    for (int i = 0; i < MW; i++)
      step("lane_write", 1'b1, 1'b1, 4'd7, $urandom, 4'(1 << i));
    step("rd7_lanes", 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    step("wr7_upper", 1'b1, 1'b1, 4'd7, 32'hA5A5A5A5, 4'b1100);
    step("rd7_upper", 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_byte_synth.md
BSG_MEM_1RW_SYNC_MASK_WRITE_BYTE_SYNTH -- requirements
Module: bsg_mem_1rw_sync_mask_write_byte_synth

Interface
REQ-001 SHALL have parameter els_p, no default (mandatory), number of words; must be >= 1.
REQ-002 SHALL have parameter data_width_p, no default (mandatory), word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter latch_last_read_p, default 1, which when 1 makes data_o hold the last read value.
REQ-004 SHALL have derived parameter addr_width_lp, default safe clog2(els_p), giving at least 1 address bit.
REQ-005 SHALL have derived parameter write_mask_width_lp, default data_width_p/8, giving one mask bit per byte.
REQ-006 SHALL have port clk_i, input, width 1: the single clock, with all state updated on its rising edge.
REQ-007 SHALL have port reset_n_i, input, width 1: reset, asynchronous and active-low.
REQ-008 SHALL have port v_i, input, width 1: access valid.
REQ-009 SHALL have port w_i, input, width 1: 1 = write, 0 = read; qualified by v_i.
REQ-010 SHALL have port addr_i, input, width addr_width_lp: word address.
REQ-011 SHALL have port data_i, input, width data_width_p: write data.
REQ-012 SHALL have port write_mask_i, input, width write_mask_width_lp: bit k enables byte k, which is data bits [8k+7:8k].
REQ-013 SHALL have port data_o, output, width data_width_p: read data.

Function
REQ-014 SHALL perform a write on a rising edge with v_i=1 and w_i=1: for every k with write_mask_i[k]=1, set mem[addr_i] byte k to data_i byte k.
REQ-015 SHALL leave bytes with mask bit 0 unchanged on a write.
REQ-016 SHALL perform a read on a rising edge with v_i=1 and w_i=0; data_o presents mem[addr_i] from that edge until at least the next rising edge (1-cycle latency).
REQ-017 SHALL return read data reflecting all writes completed on earlier edges.
REQ-018 SHALL, when latch_last_read_p=1, keep data_o stable at the last read value through idle cycles (v_i=0) and write cycles.
REQ-019 SHALL, when latch_last_read_p=0, define data_o only in the cycle after a read; otherwise it is don't-care and benches must not check it.
REQ-020 SHALL never change data_o in the cycle after a write when latch_last_read_p=1; there is no write-through.
REQ-021 SHALL do nothing when v_i=0: no state change except clock.
REQ-022 SHALL do nothing when a write has write_mask_i all zeros: no memory change, and data_o behaves as for a write.
REQ-023 SHALL produce undefined results for addr_i >= els_p (non-power-of-2 els_p); no memory entry is corrupted.
REQ-024 SHALL make every address, including 0 and els_p-1, accessible.

Reset
REQ-025 SHALL clear data_o and the internal read-address/read-valid registers to 0 immediately while reset_n_i=0, independent of clk_i.
REQ-026 SHALL NOT reset memory array contents; they are unknown until written.
REQ-027 SHALL ignore accesses presented while reset_n_i=0.
REQ-028 SHALL resume operation on the first rising edge after deassertion, with data_o remaining 0 until the first read completes.

Structure
REQ-029 SHALL use no shared package; all widths derive from parameters, and the BSG_INV_PARAM / BSG_SAFE_CLOG2 macros come from the common defines header.
REQ-030 SHALL be a single module with a behavioral 2-D array, per-byte write generate loop, and output register.
REQ-031 SHALL keep the array inferable as synchronous RAM: no reset on the array and no asynchronous read path to data_o.
REQ-032 SHALL simulation-assert data_width_p % 8 == 0 and els_p >= 1, and print an instantiation banner with parameters.

Verification
REQ-033 SHALL verify full-word write then read: with els_p=16, data_width_p=32, write addr 3 data 0xDEADBEEF mask 0xF, then read addr 3 -> data_o=0xDEADBEEF one cycle later.
REQ-034 SHALL verify partial mask: after REQ-033, write addr 3 data 0x11223344 mask 0b0101, then read -> data_o=0xDE22BE44.
REQ-035 SHALL verify hold: with latch_last_read_p=1, read addr 3, then 3 idle cycles, then write addr 5 0xCAFEF00D mask 0xF -> data_o stays 0xDE22BE44 throughout; read addr 5 -> 0xCAFEF00D.
REQ-036 SHALL verify zero mask: write addr 5 data 0xFFFFFFFF mask 0 -> read addr 5 returns 0xCAFEF00D.
REQ-037 SHALL verify async reset: assert reset_n_i=0 mid-cycle -> data_o=0 immediately without a clock edge; after release, read addr 5 -> 0xCAFEF00D (memory retained).
REQ-038 SHALL verify boundaries: write addr 0 with 0x00000001 and addr 15 with 0x80000000, then back-to-back reads of 0 and 15 -> 0x00000001 then 0x80000000 on consecutive cycles.
